dmem_responder: RTL and testbench
=================================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter WAIT_CYCLES, default 2, wait states inserted between request acceptance and response (legal 0..15).
REQ-002 Parameter DEPTH_LOG2, default 6, log2 of word count held (64 x 32-bit words).
REQ-003 CLK  input  1  single clock; all state changes on rising edge.
REQ-004 RST  input  1  reset, synchronous, active-high.
REQ-005 req  input  1  initiator request; held high until ack seen.
REQ-006 we  input  1  1 = store, 0 = load; valid with req.
REQ-007 addr  input  32  byte address; valid with req.
REQ-008 wdata  input  32  store data; valid with req and we.
REQ-009 rdata  output  32  load data; valid only while ack high.
REQ-010 ack  output  1  one-cycle response strobe.
REQ-011 err  output  1  error flag; valid only while ack high.

Function
REQ-012 FSM states IDLE, WAIT, RESP; reset state IDLE.
REQ-013 IDLE with req=1: latch we, addr, wdata; load wait counter with WAIT_CYCLES; go to WAIT, or to RESP if WAIT_CYCLES=0.
REQ-014 IDLE with req=0: remain IDLE; ack=0.
REQ-015 WAIT: decrement counter each cycle; on the cycle counter reads 1, go to RESP; total latency req-accept edge to ack = WAIT_CYCLES+1 cycles.
REQ-016 RESP: ack=1 for exactly one cycle; next state IDLE unconditionally.
REQ-017 Inputs req/we/addr/wdata ignored outside IDLE; only latched copies used.
REQ-018 Word index = latched addr[DEPTH_LOG2+1:2].
REQ-019 Error when latched addr[1:0] != 0 (misaligned) or addr[31:DEPTH_LOG2+2] != 0 (out of range).
REQ-020 Load, no error: rdata = stored word at index, err=0, during RESP.
REQ-021 Store, no error: word written at the RESP-cycle edge; rdata=0, err=0.
REQ-022 Any error: no array write; rdata=0, err=1 with ack.
REQ-023 rdata=0 and err=0 whenever ack=0.
REQ-024 Back-to-back: req high in the IDLE cycle after RESP is accepted as a new transaction; initiator drops req in the ack cycle to avoid repeat.
REQ-025 Load to an index stored by the immediately preceding transaction returns the new data.

Reset
REQ-026 RST=1 at a rising edge: state IDLE, counter 0, ack=0, err=0, rdata=0, all array words 0.
REQ-027 Reset in WAIT or RESP aborts the transaction; pending store discarded; no ack issued.
REQ-028 RST dominates req in the same cycle; request not accepted.

Structure
REQ-029 Shared package holds state encoding (IDLE=2'b00, WAIT=2'b01, RESP=2'b10), WAIT_CYCLES and DEPTH_LOG2 defaults, word width 32.
REQ-030 Storage is sub-module dmem_array: 2^DEPTH_LOG2 x 32 registers, synchronous write enable, combinational read, synchronous clear on RST.
REQ-031 FSM, counter, latches and error decode live in dmem_responder.

Verification
REQ-032 Reset then store addr=0x00000010, wdata=0xDEADBEEF, WAIT_CYCLES=2 -> ack exactly 3 cycles after accept, err=0; subsequent load 0x10 -> rdata=0xDEADBEEF.
REQ-033 Load addr=0x00000006 -> ack with err=1, rdata=0; store addr=0x00000100 -> err=1, later load of index 0 still 0.
REQ-034 Store 0x20=0x11111111 then req held high with load 0x20 -> second ack exactly WAIT_CYCLES+2 cycles after first ack, rdata=0x11111111.
REQ-035 Store 0x04=0xCAFEF00D, assert RST during WAIT -> no ack; after reset load 0x04 -> 0x00000000.
REQ-036 WAIT_CYCLES=0 build: load 0xFC after reset -> ack on cycle following accept, rdata=0, err=0.
REQ-037 Change addr/wdata during WAIT -> response uses values latched at accept.

Source files
------------

// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder: FSM encoding,
// default parameters and bus widths.
package dmem_responder_pkg;

  localparam int unsigned DATA_W          = 32;
  localparam int unsigned ADDR_W          = 32;
  localparam int unsigned WAIT_CYCLES_DEF = 2;
  localparam int unsigned DEPTH_LOG2_DEF  = 6;
  // Wide enough for the largest legal wait count (15).
  localparam int unsigned CNT_W           = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_RESP = 2'b10
  } state_e;

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response bus between an initiator and the data-memory responder.
interface dmem_responder_if;
  import dmem_responder_pkg::*;

  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              ack;
  logic              err;

  modport master (output req, we, addr, wdata, input rdata, ack, err);
  modport slave  (input req, we, addr, wdata, output rdata, ack, err);

endinterface

// File: rtl/dmem_array.sv
// Word storage for the responder: 2^DEPTH_LOG2 x 32-bit registers with a
// synchronous write port, a combinational read port and synchronous clear.
module dmem_array
  import dmem_responder_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = DEPTH_LOG2_DEF
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  we_i,
  input  logic [DEPTH_LOG2-1:0] waddr_i,
  input  logic [DATA_W-1:0]     wdata_i,
  input  logic [DEPTH_LOG2-1:0] raddr_i,
  output logic [DATA_W-1:0]     rdata_o
);

  localparam int unsigned WORDS = 1 << DEPTH_LOG2;

  logic [DATA_W-1:0] mem_q [WORDS];
  logic [DATA_W-1:0] mem_d [WORDS];

  // Next array contents: unchanged except the addressed word on a write.
  always_comb begin
    // NOTE: assigning the whole target first means every path drives it, so no latch is inferred.
    mem_d = mem_q;
    if (we_i) mem_d[waddr_i] = wdata_i;
  end

  // Array register with synchronous clear.
  always_ff @(posedge CLK) begin
    // NOTE: non-blocking updates so every flop samples pre-edge values regardless of block order.
    if (RST) begin
      // NOTE: this storage is deliberately reset (loads after reset must read zero),
      // which keeps it as plain flops; drop the clear if it is ever mapped to a RAM.
      for (int i = 0; i < int'(WORDS); i++) mem_q[i] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder: accepts a request in IDLE,
// inserts WAIT_CYCLES wait states, then strobes ack for one cycle with
// load data or an error flag. Request fields are latched at acceptance.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = WAIT_CYCLES_DEF,
  parameter int unsigned DEPTH_LOG2  = DEPTH_LOG2_DEF
) (
  input  logic         CLK,
  input  logic         RST,
  dmem_responder_if.slave bus
);

  localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(WAIT_CYCLES);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  logic [DEPTH_LOG2-1:0] word_idx;
  logic                  addr_err;
  logic                  mem_we;
  logic [DATA_W-1:0]     mem_rdata;

  // Decode is done on the latched address only, so initiator changes
  // after acceptance cannot affect the response.
  assign word_idx = addr_q[DEPTH_LOG2+1:2];
  assign addr_err = (addr_q[1:0] != 2'b00) || (addr_q[ADDR_W-1:DEPTH_LOG2+2] != '0);
  assign mem_we   = (state_q == ST_RESP) && we_q && !addr_err;

  dmem_array #(.DEPTH_LOG2(DEPTH_LOG2)) u_array (
    .CLK     (CLK),
    .RST     (RST),
    .we_i    (mem_we),
    .waddr_i (word_idx),
    .wdata_i (wdata_q),
    .raddr_i (word_idx),
    .rdata_o (mem_rdata)
  );

  // Next state, wait counter and request latches.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.req) begin
          we_d    = bus.we;
          addr_d  = bus.addr;
          wdata_d = bus.wdata;
          cnt_d   = WAIT_INIT;
          state_d = (WAIT_CYCLES == 0) ? ST_RESP : ST_WAIT;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q <= CNT_W'(1)) state_d = ST_RESP;
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Response outputs: everything is zero unless ack is up.
  always_comb begin
    bus.ack   = 1'b0;
    bus.err   = 1'b0;
    bus.rdata = '0;
    if (state_q == ST_RESP) begin
      bus.ack = 1'b1;
      bus.err = addr_err;
      if (!addr_err && !we_q) bus.rdata = mem_rdata;
    end
  end

  // State and latch registers; reset aborts any transaction in flight.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: a WAIT_CYCLES=2 instance for the
// main scenarios and a WAIT_CYCLES=0 instance for the zero-wait build.
module tb_dmem_responder;
  import dmem_responder_pkg::*;

  localparam int W  = 2;
  localparam int DL = 6;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } exp_t;

  typedef struct {
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
  } stim_t;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  dmem_responder_if bus  ();
  dmem_responder_if bus0 ();

  dmem_responder #(.WAIT_CYCLES(W), .DEPTH_LOG2(DL)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  dmem_responder #(.WAIT_CYCLES(0), .DEPTH_LOG2(DL)) dut0 (
    .CLK (CLK),
    .RST (RST),
    .bus (bus0)
  );

  exp_t        sb[$];
  logic [31:0] ref_mem [2][64];
  int          vectors     = 0;
  int          miscompares = 0;

  function automatic logic model_err(input logic [31:0] a);
    return (a[1:0] != 2'b00) || (a[31:8] != 24'h0);
  endfunction

  task automatic clear_model();
    for (int s = 0; s < 2; s++)
      for (int i = 0; i < 64; i++) ref_mem[s][i] = 32'h0;
    sb.delete();
  endtask

  // Drive a request and push the response the model predicts for it.
  task automatic issue(input bit sel, input logic w, input logic [31:0] a,
                       input logic [31:0] d, input int lat);
    exp_t e;
    if (sel) begin
      bus0.req = 1'b1; bus0.we = w; bus0.addr = a; bus0.wdata = d;
    end else begin
      bus.req = 1'b1; bus.we = w; bus.addr = a; bus.wdata = d;
    end
    e.err   = model_err(a);
    e.rdata = (!e.err && !w) ? ref_mem[sel][a[7:2]] : 32'h0;
    if (w && !e.err) ref_mem[sel][a[7:2]] = d;
    e.lat = lat;
    sb.push_back(e);
  endtask

  task automatic release_req(input bit sel);
    if (sel) bus0.req = 1'b0;
    else     bus.req  = 1'b0;
  endtask

  // Count edges until ack; outputs must stay quiet while ack is low.
  task automatic wait_ack(input bit sel, output int n, output logic [31:0] rd,
                          output logic er, output bit got);
    logic        a;
    logic [31:0] r;
    logic        e;
    n = 0; got = 1'b0; rd = 'x; er = 1'bx;
    while (n < 40 && !got) begin
      @(posedge CLK); #1;
      n++;
      a = sel ? bus0.ack   : bus.ack;
      r = sel ? bus0.rdata : bus.rdata;
      e = sel ? bus0.err   : bus.err;
      if (a === 1'b1) begin
        got = 1'b1; rd = r; er = e;
      end else begin
        vectors++;
        if (r !== 32'h0 || e !== 1'b0) begin
          miscompares++;
          $display("FAIL idle_outputs dut%0d rdata=%h err=%b while ack low, need 0/0", sel, r, e);
        end
      end
    end
  endtask

  // One full transaction: drive, wait for ack, drop req, confirm the strobe ends.
  task automatic run_txn(input bit sel, input logic w, input logic [31:0] a,
                         input logic [31:0] d, input int lat, output bit got,
                         output int n, output logic [31:0] rd, output logic er);
    logic a2;
    issue(sel, w, a, d, lat);
    wait_ack(sel, n, rd, er, got);
    release_req(sel);
    @(posedge CLK); #1;
    a2 = sel ? bus0.ack : bus.ack;
    vectors++;
    if (a2 !== 1'b0) begin
      miscompares++;
      $display("FAIL ack_width dut%0d addr=%h ack=%b one cycle after ack, need 0", sel, a, a2);
    end
  endtask

  task automatic test_reset();
    RST = 1'b1;
    bus.req  = 1'b1; bus.we  = 1'b0; bus.addr  = 32'h0; bus.wdata  = 32'h0;
    bus0.req = 1'b1; bus0.we = 1'b0; bus0.addr = 32'h0; bus0.wdata = 32'h0;
    repeat (3) begin
      @(posedge CLK); #1;
      vectors++;
      if (bus.ack !== 1'b0 || bus.err !== 1'b0 || bus.rdata !== 32'h0 ||
          bus0.ack !== 1'b0 || bus0.err !== 1'b0 || bus0.rdata !== 32'h0) begin
        miscompares++;
        $display("FAIL reset_outputs ack=%b/%b err=%b/%b rdata=%h/%h, need all 0",
                 bus.ack, bus0.ack, bus.err, bus0.err, bus.rdata, bus0.rdata);
      end
    end
    RST = 1'b0; bus.req = 1'b0; bus0.req = 1'b0;
    clear_model();
    repeat (W + 3) begin
      @(posedge CLK); #1;
      vectors++;
      if (bus.ack !== 1'b0 || bus0.ack !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_dominates ack=%b/%b after reset with req, need 0/0", bus.ack, bus0.ack);
      end
    end
  endtask

  task automatic test_zero_wait();
    stim_t tbl[$] = '{'{1'b0, 32'h000000FC, 32'h0},
                      '{1'b1, 32'h00000000, 32'h12345678},
                      '{1'b0, 32'h00000000, 32'h0}};
    bit got; int n; logic [31:0] rd; logic er; exp_t e;
    for (int i = 0; i < tbl.size(); i++) begin
      run_txn(1'b1, tbl[i].w, tbl[i].a, tbl[i].d, 1, got, n, rd, er);
      e = sb.pop_front();
      vectors++;
      if (!got || n !== e.lat || rd !== e.rdata || er !== e.err) begin
        miscompares++;
        $display("FAIL zero_wait[%0d] got=%b lat=%0d rdata=%h err=%b, need lat=%0d rdata=%h err=%b",
                 i, got, n, rd, er, e.lat, e.rdata, e.err);
      end
    end
  endtask

  task automatic test_store_load();
    stim_t tbl[$] = '{'{1'b1, 32'h00000010, 32'hDEADBEEF},
                      '{1'b1, 32'h000000FC, 32'h0BADF00D},
                      '{1'b0, 32'h00000014, 32'h0},
                      '{1'b0, 32'h000000FC, 32'h0},
                      '{1'b0, 32'h00000010, 32'h0}};
    bit got; int n; logic [31:0] rd; logic er; exp_t e;
    for (int i = 0; i < tbl.size(); i++) begin
      run_txn(1'b0, tbl[i].w, tbl[i].a, tbl[i].d, W + 1, got, n, rd, er);
      e = sb.pop_front();
      vectors++;
      if (!got || n !== e.lat || rd !== e.rdata || er !== e.err) begin
        miscompares++;
        $display("FAIL store_load[%0d] got=%b lat=%0d rdata=%h err=%b, need lat=%0d rdata=%h err=%b",
                 i, got, n, rd, er, e.lat, e.rdata, e.err);
      end
    end
    vectors++;
    if (rd !== 32'hDEADBEEF) begin
      miscompares++;
      $display("FAIL store_load_final rdata=%h, need deadbeef", rd);
    end
  endtask

  task automatic test_errors();
    stim_t tbl[$] = '{'{1'b0, 32'h00000006, 32'h0},
                      '{1'b1, 32'h00000100, 32'hFFFFFFFF},
                      '{1'b0, 32'h00000000, 32'h0},
                      '{1'b1, 32'h00000013, 32'h77777777},
                      '{1'b0, 32'h00000001, 32'h0},
                      '{1'b0, 32'h80000000, 32'h0},
                      '{1'b0, 32'h00000010, 32'h0}};
    bit got; int n; logic [31:0] rd; logic er; exp_t e;
    for (int i = 0; i < tbl.size(); i++) begin
      run_txn(1'b0, tbl[i].w, tbl[i].a, tbl[i].d, W + 1, got, n, rd, er);
      e = sb.pop_front();
      vectors++;
      if (!got || n !== e.lat || rd !== e.rdata || er !== e.err) begin
        miscompares++;
        $display("FAIL errors[%0d] addr=%h got=%b lat=%0d rdata=%h err=%b, need lat=%0d rdata=%h err=%b",
                 i, tbl[i].a, got, n, rd, er, e.lat, e.rdata, e.err);
      end
    end
  endtask

  task automatic test_back_to_back();
    bit got; int n; logic [31:0] rd; logic er; exp_t e;
    issue(1'b0, 1'b1, 32'h00000020, 32'h11111111, W + 1);
    wait_ack(1'b0, n, rd, er, got);
    e = sb.pop_front();
    vectors++;
    if (!got || n !== e.lat || rd !== e.rdata || er !== e.err) begin
      miscompares++;
      $display("FAIL b2b_store got=%b lat=%0d rdata=%h err=%b, need lat=%0d rdata=%h err=%b",
               got, n, rd, er, e.lat, e.rdata, e.err);
    end
    // req stays high through the ack cycle, now carrying a load.
    issue(1'b0, 1'b0, 32'h00000020, 32'h0, W + 2);
    wait_ack(1'b0, n, rd, er, got);
    release_req(1'b0);
    e = sb.pop_front();
    vectors++;
    if (!got || n !== e.lat || rd !== 32'h11111111 || er !== e.err) begin
      miscompares++;
      $display("FAIL b2b_load got=%b lat=%0d rdata=%h err=%b, need lat=%0d rdata=11111111 err=%b",
               got, n, rd, er, e.lat, e.err);
    end
    repeat (W + 3) begin
      @(posedge CLK); #1;
      vectors++;
      if (bus.ack !== 1'b0) begin
        miscompares++;
        $display("FAIL b2b_no_repeat ack=%b after req dropped, need 0", bus.ack);
      end
    end
  endtask

  task automatic test_latch_hold();
    stim_t tbl[$] = '{'{1'b0, 32'h00000008, 32'h0},
                      '{1'b0, 32'h0000000C, 32'h0}};
    bit got; int n; logic [31:0] rd; logic er; exp_t e;
    issue(1'b0, 1'b1, 32'h00000008, 32'hA5A5A5A5, W + 1);
    @(posedge CLK); #1;
    bus.we = 1'b0; bus.addr = 32'h0000000C; bus.wdata = 32'h5A5A5A5A;
    wait_ack(1'b0, n, rd, er, got);
    n = n + 1;
    release_req(1'b0);
    e = sb.pop_front();
    vectors++;
    if (!got || n !== e.lat || rd !== e.rdata || er !== e.err) begin
      miscompares++;
      $display("FAIL latch_store got=%b lat=%0d rdata=%h err=%b, need lat=%0d rdata=%h err=%b",
               got, n, rd, er, e.lat, e.rdata, e.err);
    end
    @(posedge CLK); #1;
    for (int i = 0; i < tbl.size(); i++) begin
      run_txn(1'b0, tbl[i].w, tbl[i].a, tbl[i].d, W + 1, got, n, rd, er);
      e = sb.pop_front();
      vectors++;
      if (!got || n !== e.lat || rd !== e.rdata || er !== e.err) begin
        miscompares++;
        $display("FAIL latch_load[%0d] got=%b lat=%0d rdata=%h err=%b, need lat=%0d rdata=%h err=%b",
                 i, got, n, rd, er, e.lat, e.rdata, e.err);
      end
      if (i == 0) begin
        vectors++;
        if (rd !== 32'hA5A5A5A5) begin
          miscompares++;
          $display("FAIL latch_value rdata=%h, need a5a5a5a5", rd);
        end
      end
    end
  endtask

  task automatic test_reset_abort();
    stim_t tbl[$] = '{'{1'b0, 32'h00000004, 32'h0},
                      '{1'b0, 32'h00000010, 32'h0}};
    bit got; int n; logic [31:0] rd; logic er; exp_t e;
    issue(1'b0, 1'b1, 32'h00000004, 32'hCAFEF00D, W + 1);
    @(posedge CLK); #1;
    RST = 1'b1; bus.req = 1'b0;
    @(posedge CLK); #1;
    RST = 1'b0;
    clear_model();
    repeat (W + 4) begin
      @(posedge CLK); #1;
      vectors++;
      if (bus.ack !== 1'b0) begin
        miscompares++;
        $display("FAIL abort_no_ack ack=%b after reset in WAIT, need 0", bus.ack);
      end
    end
    for (int i = 0; i < tbl.size(); i++) begin
      run_txn(1'b0, tbl[i].w, tbl[i].a, tbl[i].d, W + 1, got, n, rd, er);
      e = sb.pop_front();
      vectors++;
      if (!got || n !== e.lat || rd !== 32'h0 || er !== e.err) begin
        miscompares++;
        $display("FAIL abort_load[%0d] got=%b lat=%0d rdata=%h err=%b, need lat=%0d rdata=00000000 err=%b",
                 i, got, n, rd, er, e.lat, e.err);
      end
    end
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_store_load();
    test_errors();
    test_back_to_back();
    test_latch_hold();
    test_reset_abort();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
